// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered decode stage. Turns the IF/ID opcode
// into ID/EX control bits and inserts bubbles for load-use, flush, illegal.
// Ports:
//   clk, reset (async, active-high)
//   instr_valid, opcode, rs1_id, rs2_id, rd_id : IF/ID instruction
//   flush : kill ID instruction; ex_stall : hold ID/EX
//   illegal_ack : leave the trap state
//   ex_valid, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg,
//   ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op, ex_rd : ID/EX regs
//   stall_id : combinational freeze for PC and IF/ID
//   illegal_trap : registered, high in TRAP; trap_count : saturating count
// Optional macro JUMP_DECODE_EN adds JAL/JALR/LUI/AUIPC decode; without it
// those opcodes are illegal and ex_jump is tied low.
module pipelined_control_unit #(
   parameter int ALUOP_W = 3,
   parameter int REG_W   = 5,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [6:0]         opcode,
   input  logic [REG_W-1:0]   rs1_id,
   input  logic [REG_W-1:0]   rs2_id,
   input  logic [REG_W-1:0]   rd_id,
   input  logic               flush,
   input  logic               ex_stall,
   input  logic               illegal_ack,
   output logic               ex_valid,
   output logic               ex_branch,
   output logic               ex_jump,
   output logic               ex_mem_read,
   output logic               ex_mem_to_reg,
   output logic               ex_mem_write,
   output logic               ex_alu_src,
   output logic               ex_reg_write,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [REG_W-1:0]   ex_rd,
   output logic               stall_id,
   output logic               illegal_trap,
   output logic [CNT_W-1:0]   trap_count
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_NOP   = 7'b0000000;
`ifdef JUMP_DECODE_EN
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

   typedef enum logic {
      IDLE = 1'b0,
      TRAP = 1'b1
   } state_t;

   typedef struct packed {
      logic               valid;
      logic               branch;
      logic               mem_read;
      logic               mem_to_reg;
      logic               mem_write;
      logic               alu_src;
      logic               reg_write;
      logic [ALUOP_W-1:0] alu_op;
      logic [REG_W-1:0]   rd;
   } ctl_t;

   ctl_t             dec;
   logic             dec_jump;
   logic             dec_legal;
   ctl_t             ctl_d, ctl_q;
   logic             jump_d, jump_q;
   state_t           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             hazard;
   logic             in_trap;

   // Opcode decode. NOP is legal but produces the all-zero bubble.
   always_comb begin
      dec       = '0;
      dec_jump  = 1'b0;
      dec_legal = 1'b1;
      unique case (1'b1)
         (opcode == OP_R): begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(2);
         end
         (opcode == OP_LOAD): begin
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
         end
         (opcode == OP_STORE): begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         (opcode == OP_BR): begin
            dec.branch = 1'b1;
            dec.alu_op = ALUOP_W'(1);
         end
         (opcode == OP_IALU): begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(3);
         end
`ifdef JUMP_DECODE_EN
         (opcode == OP_JAL): begin
            dec_jump      = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(4);
         end
         (opcode == OP_JALR): begin
            dec_jump      = 1'b1;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(4);
         end
         (opcode == OP_LUI): begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(5);
         end
         (opcode == OP_AUIPC): begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = ALUOP_W'(6);
         end
`endif
         (opcode == OP_NOP): begin
         end
         default: dec_legal = 1'b0;
      endcase
      if (opcode != OP_NOP && dec_legal) begin
         dec.valid = 1'b1;
         dec.rd    = rd_id;
      end
   end

   assign in_trap = (state_q == TRAP);

   // Load-use: the load in EX writes a register the ID instruction reads.
   assign hazard = instr_valid & ctl_q.valid & ctl_q.mem_read &
                   (ctl_q.rd != '0) &
                   ((ctl_q.rd == rs1_id) | (ctl_q.rd == rs2_id));

   assign stall_id = hazard | in_trap | ex_stall;

   // ID/EX next value; flush outranks ex_stall so a killed
   // instruction never lingers in a held register.
   always_comb begin
      ctl_d  = ctl_q;
      jump_d = jump_q;
      if (flush) begin
         ctl_d  = '0;
         jump_d = 1'b0;
      end else if (ex_stall) begin
         ctl_d  = ctl_q;
         jump_d = jump_q;
      end else if (in_trap || hazard || !instr_valid || !dec_legal) begin
         ctl_d  = '0;
         jump_d = 1'b0;
      end else begin
         ctl_d  = dec;
         jump_d = dec_jump;
      end
   end

   // Trap FSM. Entry only when the illegal instruction would really
   // have issued this cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (instr_valid && !dec_legal && !flush &&
                !ex_stall && !hazard) begin
               state_d = TRAP;
               if (cnt_q != '1)
                  cnt_d = cnt_q + 1'b1;
            end
         end
         TRAP: begin
            if (illegal_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctl_q   <= '0;
         jump_q  <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         ctl_q   <= ctl_d;
         jump_q  <= jump_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid      = ctl_q.valid;
   assign ex_branch     = ctl_q.branch;
   assign ex_mem_read   = ctl_q.mem_read;
   assign ex_mem_to_reg = ctl_q.mem_to_reg;
   assign ex_mem_write  = ctl_q.mem_write;
   assign ex_alu_src    = ctl_q.alu_src;
   assign ex_reg_write  = ctl_q.reg_write;
   assign ex_alu_op     = ctl_q.alu_op;
   assign ex_rd         = ctl_q.rd;
   assign illegal_trap  = in_trap;
   assign trap_count    = cnt_q;

`ifdef JUMP_DECODE_EN
   assign ex_jump = jump_q;
`else
   assign ex_jump = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed plan cases plus randomized traffic
// checked against an opcode-table reference model of the decode stage.
module tb_pipelined_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid;
   logic [6:0] opcode;
   logic [4:0] rs1_id, rs2_id, rd_id;
   logic       flush, ex_stall, illegal_ack;
   logic       ex_valid, ex_branch, ex_jump, ex_mem_read;
   logic       ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [2:0] ex_alu_op;
   logic [4:0] ex_rd;
   logic       stall_id, illegal_trap;
   logic [1:0] trap_count;

   int n_checks = 0;
   int n_errors = 0;

   pipelined_control_unit #(
      .ALUOP_W(3), .REG_W(5), .CNT_W(2)
   ) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid),
      .opcode(opcode), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .flush(flush), .ex_stall(ex_stall), .illegal_ack(illegal_ack),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
      .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
      .stall_id(stall_id), .illegal_trap(illegal_trap),
      .trap_count(trap_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit v, br, j, mr, m2r, mw, as, rw;
      bit [2:0] alu;
      bit [4:0] rd;
   } mctl_t;

   mctl_t m_ex;
   bit    m_trap;
   int    m_cnt;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Spec opcode table; rd only travels with a real instruction.
   function automatic void ref_decode(input bit [6:0] op, input bit [4:0] rd,
                                      output mctl_t c, output bit illegal);
      c = '0;
      illegal = 1'b0;
      case (op)
         7'b0110011: begin c.rw = 1; c.alu = 2; end
         7'b0000011: begin c.as = 1; c.m2r = 1; c.rw = 1; c.mr = 1; end
         7'b0100011: begin c.as = 1; c.mw = 1; end
         7'b1100011: begin c.br = 1; c.alu = 1; end
         7'b0010011: begin c.as = 1; c.rw = 1; c.alu = 3; end
         7'b0000000: ;
`ifdef JUMP_DECODE_EN
         7'b1101111: begin c.j = 1; c.rw = 1; c.alu = 4; end
         7'b1100111: begin c.j = 1; c.as = 1; c.rw = 1; c.alu = 4; end
         7'b0110111: begin c.as = 1; c.rw = 1; c.alu = 5; end
         7'b0010111: begin c.as = 1; c.rw = 1; c.alu = 6; end
`endif
         default: illegal = 1'b1;
      endcase
      if (!illegal && op != 7'b0) begin
         c.v = 1;
         c.rd = rd;
      end
   endfunction

   function automatic bit ref_hazard();
      return instr_valid && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
             (m_ex.rd == rs1_id || m_ex.rd == rs2_id);
   endfunction

   task automatic ref_reset();
      m_ex = '0;
      m_trap = 1'b0;
      m_cnt = 0;
   endtask

   task automatic ref_edge();
      mctl_t c;
      bit    ill, hz;
      ref_decode(opcode, rd_id, c, ill);
      hz = ref_hazard();
      if (flush) m_ex = '0;
      else if (ex_stall) m_ex = m_ex;
      else if (m_trap || hz || !instr_valid || ill) m_ex = '0;
      else m_ex = c;
      if (m_trap) begin
         if (illegal_ack) m_trap = 1'b0;
      end else if (instr_valid && ill && !flush && !ex_stall && !hz) begin
         m_trap = 1'b1;
         if (m_cnt < 3) m_cnt++;
      end
   endtask

   task automatic check_regs();
      chk("ctl", {ex_valid, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg,
                  ex_mem_write, ex_alu_src, ex_reg_write},
          {m_ex.v, m_ex.br, m_ex.j, m_ex.mr, m_ex.m2r, m_ex.mw, m_ex.as,
           m_ex.rw});
      chk("alu_op", ex_alu_op, m_ex.alu);
      chk("ex_rd", ex_rd, m_ex.rd);
      chk("illegal_trap", illegal_trap, m_trap);
      chk("trap_count", trap_count, m_cnt);
   endtask

   // Called at a negedge: drive, check stall, clock, check registers.
   task automatic cycle(input bit iv, input bit [6:0] op, input bit [4:0] r1,
                        input bit [4:0] r2, input bit [4:0] rd, input bit fl,
                        input bit st, input bit ack);
      instr_valid = iv; opcode = op; rs1_id = r1; rs2_id = r2; rd_id = rd;
      flush = fl; ex_stall = st; illegal_ack = ack;
      #1;
      chk("stall_id", stall_id, ref_hazard() || m_trap || st);
      @(posedge clk);
      ref_edge();
      @(negedge clk);
      check_regs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      ref_reset();
      check_regs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle();
      cycle(0, 7'h00, 0, 0, 0, 0, 0, 0);
   endtask

   bit [6:0] op_tab [11] = '{7'b0110011, 7'b0000011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b0010011, 7'b0000000, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b1111111};

   initial begin
      reset = 1'b1;
      instr_valid = 0; opcode = 0; rs1_id = 0; rs2_id = 0; rd_id = 0;
      flush = 0; ex_stall = 0; illegal_ack = 0;
      ref_reset();
      repeat (2) @(negedge clk);
      check_regs();
      reset = 1'b0;

      // R-type issue
      cycle(1, 7'b0110011, 1, 2, 5, 0, 0, 0);
      chk("r_alu_op", ex_alu_op, 3'd2);
      chk("r_rd", ex_rd, 5'd5);
      chk("r_valid", ex_valid, 1'b1);

      // load rd=7 then R-type reading x7: one stall, one bubble
      cycle(1, 7'b0000011, 1, 2, 7, 0, 0, 0);
      cycle(1, 7'b0110011, 3, 7, 8, 0, 0, 0);
      chk("lu_bubble", ex_valid, 1'b0);
      cycle(1, 7'b0110011, 3, 7, 8, 0, 0, 0);
      chk("lu_issue_rd", ex_rd, 5'd8);

      // load rd=0 never stalls
      cycle(1, 7'b0000011, 0, 0, 0, 0, 0, 0);
      cycle(1, 7'b0110011, 0, 0, 9, 0, 0, 0);
      chk("rd0_issue", ex_valid, 1'b1);

      // branch killed by flush; flush also beats ex_stall
      cycle(1, 7'b1100011, 1, 2, 0, 1, 0, 0);
      chk("flush_bubble", ex_valid, 1'b0);
      cycle(1, 7'b0010011, 1, 2, 4, 0, 0, 0);
      repeat (3) cycle(1, 7'b0100011, 1, 2, 3, 0, 1, 0);
      chk("hold_alu", ex_alu_op, 3'd3);
      cycle(1, 7'b0100011, 1, 2, 3, 1, 1, 0);
      chk("flush_stall", ex_valid, 1'b0);

      // illegal opcode: trap until ack, flush does not exit
      cycle(1, 7'b1111111, 1, 2, 3, 0, 0, 0);
      chk("trap_on", illegal_trap, 1'b1);
      chk("trap_cnt1", trap_count, 2'd1);
      cycle(1, 7'b0110011, 1, 2, 3, 1, 0, 0);
      cycle(1, 7'b0110011, 1, 2, 3, 0, 0, 1);
      chk("trap_off", illegal_trap, 1'b0);
      cycle(1, 7'b0110011, 1, 2, 3, 0, 0, 0);

      // reset mid-trap
      cycle(1, 7'b1111111, 1, 2, 3, 0, 0, 0);
      do_reset();

      // JAL: decoded with the macro, illegal without
      cycle(1, 7'b1101111, 1, 2, 6, 0, 0, 0);
`ifdef JUMP_DECODE_EN
      chk("jal_jump", ex_jump, 1'b1);
      chk("jal_alu", ex_alu_op, 3'd4);
`else
      chk("jal_trap", illegal_trap, 1'b1);
      chk("jal_cnt", trap_count, 2'd1);
`endif
      do_reset();

      // saturation at 3 with CNT_W=2
      for (int i = 0; i < 5; i++) begin
         cycle(1, 7'b1011011, 1, 2, 3, 0, 0, 0);
         cycle(0, 7'b0, 0, 0, 0, 0, 0, 1);
      end
      chk("sat_cnt", trap_count, 2'd3);
      idle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit [6:0] op;
         int k;
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end
         k = $urandom_range(0, 11);
         op = (k == 11) ? 7'($urandom) : op_tab[k];
         cycle($urandom_range(0, 7) != 0, op,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
